// File: rtl/fp_horner_eval.sv
// Iterative polynomial evaluator: P(x) = c[DEGREE]*x^DEGREE + ... + c[0] by Horner's rule
// on a single truncating fp32 multiplier and adder, one MUL/ADD pair per coefficient.
module fp_horner_eval #(
  parameter int DEGREE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        coef_we,
  input  logic [3:0]  coef_addr,
  input  logic [31:0] coef_data,
  input  logic        start,
  input  logic [31:0] x,
  output logic        busy,
  output logic        done,
  output logic [31:0] y,
  output logic        ovf
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MUL,
    S_ADD,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] c [0:DEGREE];
  logic [31:0] acc;
  logic [31:0] x_r;
  logic [3:0]  k;
  logic        nan_r;
  logic [31:0] coef_k;
  logic [32:0] mul_res;
  logic [32:0] add_res;
  logic        mul_nan;
  logic        add_nan;

  // Truncating multiply. Exponent-0 operands are zero; an exponent-255 acc is treated as
  // 1.m * 2^128 so an overflowed acc keeps saturating. Result {overflow, value}.
  function automatic logic [32:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0]        p;
    logic signed [10:0] e;
    logic [22:0]        m;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 33'd0;
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]}) - 11'sd127;
    if (p[47]) begin
      m = 23'(p >> 24);
      e = e + 11'sd1;
    end else begin
      m = 23'(p >> 23);
    end
    if (e > 11'sd254) return {1'b1, a[31] ^ b[31], 8'hFF, 23'd0};
    if (e < 11'sd1) return 33'd0;
    return {1'b0, a[31] ^ b[31], e[7:0], m};
  endfunction

  // Truncating add with guard/round/sticky bits, which is enough to truncate the exact
  // sum correctly even when a far-smaller operand is subtracted.
  function automatic logic [32:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]        big;
    logic [31:0]        sml;
    logic [7:0]         d;
    logic [4:0]         d_cap;
    logic [53:0]        tmp;
    logic [26:0]        ax;
    logic [26:0]        bx;
    logic [26:0]        diff;
    logic [27:0]        sum;
    logic [22:0]        m;
    logic signed [10:0] e;
    logic [4:0]         lz;
    logic               found;
    if (a[30:23] == 8'd0) return (b[30:23] == 8'd0) ? 33'd0 : {1'b0, b};
    if (b[30:23] == 8'd0) return {1'b0, a};
    if (b[30:0] > a[30:0]) begin
      big = b;
      sml = a;
    end else begin
      big = a;
      sml = b;
    end
    d     = big[30:23] - sml[30:23];
    d_cap = (d > 8'd27) ? 5'd27 : d[4:0];
    tmp   = {1'b1, sml[22:0], 30'd0} >> d_cap;
    ax    = {1'b1, big[22:0], 3'b000};
    bx    = {tmp[53:28], tmp[27] | (|tmp[26:0])};
    e     = $signed({3'b000, big[30:23]});
    if (big[31] == sml[31]) begin
      sum = {1'b0, ax} + {1'b0, bx};
      if (sum[27]) begin
        m = 23'(sum >> 4);
        e = e + 11'sd1;
      end else begin
        m = 23'(sum >> 3);
      end
    end else begin
      diff = ax - bx;
      if (diff == 27'd0) return 33'd0;
      lz    = 5'd0;
      found = 1'b0;
      for (int i = 26; i >= 0; i--) begin
        if (!found) begin
          if (diff[i]) found = 1'b1;
          else         lz = lz + 5'd1;
        end
      end
      diff = diff << lz;
      m    = 23'(diff >> 3);
      e    = e - $signed({6'd0, lz});
    end
    if (e > 11'sd254) return {1'b1, big[31], 8'hFF, 23'd0};
    if (e < 11'sd1) return 33'd0;
    return {1'b0, big[31], e[7:0], m};
  endfunction

  always_comb begin
    coef_k = 32'd0;
    for (int i = 0; i <= DEGREE; i++) begin
      if (k == 4'(i)) coef_k = c[i];
    end
    mul_res = fp_mul(acc, x_r);
    add_res = fp_add(acc, coef_k);
    mul_nan = nan_r || (x_r[30:23] == 8'hFF);
    add_nan = nan_r || (coef_k[30:23] == 8'hFF);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: state_nxt = S_MUL;
      S_MUL:  state_nxt = S_ADD;
      S_ADD:  state_nxt = (k == 4'd0) ? S_DONE : S_MUL;
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // y is loaded on the final ADD so it is already valid during the done cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= 32'd0;
      x_r   <= 32'd0;
      y     <= 32'd0;
      ovf   <= 1'b0;
      nan_r <= 1'b0;
      k     <= 4'd0;
      for (int i = 0; i <= DEGREE; i++) c[i] <= 32'd0;
    end else begin
      if (coef_we && !busy) begin
        for (int i = 0; i <= DEGREE; i++) begin
          if (coef_addr == 4'(i)) c[i] <= coef_data;
        end
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            x_r   <= x;
            ovf   <= 1'b0;
            nan_r <= 1'b0;
          end
        end
        S_LOAD: begin
          k <= 4'(DEGREE - 1);
          if (c[DEGREE][30:23] == 8'hFF) begin
            acc   <= QNAN;
            nan_r <= 1'b1;
            ovf   <= 1'b1;
          end else begin
            acc <= c[DEGREE];
          end
        end
        S_MUL: begin
          if (mul_nan) begin
            acc   <= QNAN;
            nan_r <= 1'b1;
            ovf   <= 1'b1;
          end else begin
            acc <= mul_res[31:0];
            if (mul_res[32]) ovf <= 1'b1;
          end
        end
        S_ADD: begin
          if (add_nan) begin
            acc   <= QNAN;
            nan_r <= 1'b1;
            ovf   <= 1'b1;
          end else begin
            acc <= add_res[31:0];
            if (add_res[32]) ovf <= 1'b1;
          end
          if (k == 4'd0) y <= add_nan ? QNAN : add_res[31:0];
          else           k <= k - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_horner_eval.sv
// Bench for fp_horner_eval: directed vector table, hand-built multi-cycle sequences,
// and random polynomials checked against an exact-arithmetic reference model.
module tb_fp_horner_eval;

  localparam int DEG = 4;
  localparam int LAT = 2 * DEG + 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        coef_we;
  logic [3:0]  coef_addr;
  logic [31:0] coef_data;
  logic        start;
  logic [31:0] x;
  logic        busy;
  logic        done;
  logic [31:0] y;
  logic        ovf;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q [$];
  logic        exp_ovf_q [$];
  logic [31:0] model_c [0:DEG];
  logic [31:0] last_y;

  typedef struct {
    logic [31:0] c [0:DEG];
    logic [31:0] xv;
    logic [31:0] yv;
    logic        ov;
  } vec_t;

  vec_t vecs [10];

  fp_horner_eval #(.DEGREE(DEG)) dut (
    .clk       (clk),
    .reset     (reset),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .start     (start),
    .x         (x),
    .busy      (busy),
    .done      (done),
    .y         (y),
    .ovf       (ovf)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Values are exact integers times a power of two; only the final packing truncates.
  function automatic logic [31:0] ref_pack(input logic s, input logic [299:0] m,
                                           input int lsb_e, output logic of);
    int          p;
    int          ef;
    logic [299:0] sh;
    of = 1'b0;
    p  = 0;
    for (int i = 0; i < 300; i++) if (m[i]) p = i;
    ef = p + lsb_e + 127;
    if (ef > 254) begin
      of = 1'b1;
      return {s, 8'hFF, 23'd0};
    end
    if (ef < 1) return 32'd0;
    sh = (p >= 23) ? (m >> (p - 23)) : (m << (23 - p));
    return {s, ef[7:0], sh[22:0]};
  endfunction

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          output logic of);
    logic [299:0] m;
    of = 1'b0;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 32'd0;
    m = 300'({1'b1, a[22:0]}) * 300'({1'b1, b[22:0]});
    return ref_pack(a[31] ^ b[31], m, int'(a[30:23]) - 150 + int'(b[30:23]) - 150, of);
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                          output logic of);
    logic [299:0] ma;
    logic [299:0] mb;
    of = 1'b0;
    if (a[30:23] == 8'd0) return (b[30:23] == 8'd0) ? 32'd0 : b;
    if (b[30:23] == 8'd0) return a;
    ma = 300'({1'b1, a[22:0]}) << (int'(a[30:23]) - 1);
    mb = 300'({1'b1, b[22:0]}) << (int'(b[30:23]) - 1);
    if (a[31] == b[31]) return ref_pack(a[31], ma + mb, -149, of);
    if (ma == mb) return 32'd0;
    if (ma > mb) return ref_pack(a[31], ma - mb, -149, of);
    return ref_pack(b[31], mb - ma, -149, of);
  endfunction

  function automatic logic [31:0] ref_eval(input logic [31:0] xv, output logic of);
    logic [31:0] acc;
    logic        nan;
    logic        o;
    of  = 1'b0;
    nan = (model_c[DEG][30:23] == 8'hFF);
    acc = model_c[DEG];
    for (int kk = DEG - 1; kk >= 0; kk--) begin
      if (nan || xv[30:23] == 8'hFF) nan = 1'b1;
      else begin
        acc = ref_mul(acc, xv, o);
        of  = of | o;
      end
      if (nan || model_c[kk][30:23] == 8'hFF) nan = 1'b1;
      else begin
        acc = ref_add(acc, model_c[kk], o);
        of  = of | o;
      end
    end
    if (nan) begin
      of = 1'b1;
      return 32'h7FC0_0000;
    end
    return acc;
  endfunction

  function automatic logic [31:0] rand_fp(input int lo, input int hi);
    int         r;
    logic [7:0] e;
    r = $urandom_range(0, 59);
    if (r == 0) return 32'd0;
    if (r == 1) return {1'($urandom_range(0, 1)), 8'h00, 23'($urandom)};
    if (r == 2) return {1'($urandom_range(0, 1)), 8'hFF, 23'($urandom)};
    if (r == 3)      e = 8'($urandom_range(250, 254));
    else if (r == 4) e = 8'($urandom_range(1, 4));
    else             e = 8'($urandom_range(lo, hi));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  // ---------------- scoreboard helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    start   = 1'b0;
    coef_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i <= DEG; i++) model_c[i] = 32'd0;
    last_y = 32'd0;
  endtask

  task automatic write_coef(input logic [3:0] addr, input logic [31:0] data);
    @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = addr;
    coef_data = data;
    @(negedge clk);
    coef_we = 1'b0;
    if (int'(addr) <= DEG) model_c[addr] = data;
  endtask

  // Ends sampling the done cycle; b2b starts in the very next (IDLE) cycle.
  task automatic run_eval(input logic [31:0] xv, input bit b2b,
                          output logic [31:0] yv, output logic ov);
    int lat;
    bit busy_bad;
    @(negedge clk);
    check("idle_done_low", {31'd0, done}, 32'd0);
    check("idle_busy_low", {31'd0, busy}, 32'd0);
    if (!b2b) repeat (2) @(negedge clk);
    check("y_hold", y, last_y);
    start = 1'b1;
    x     = xv;
    @(negedge clk);
    start = 1'b0;
    x     = 32'($urandom);
    lat   = 1;
    busy_bad = 1'b0;
    check("ovf_cleared", {31'd0, ovf}, 32'd0);
    while (!done && lat < 40) begin
      if (!busy) busy_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (!busy) busy_bad = 1'b1;
    check("busy_window", {31'd0, busy_bad}, 32'd0);
    check("latency", 32'(lat), 32'(LAT));
    yv     = y;
    ov     = ovf;
    last_y = y;
  endtask

  task automatic set_vec(input int i, input logic [31:0] c4, input logic [31:0] c3,
                         input logic [31:0] c2, input logic [31:0] c1, input logic [31:0] c0,
                         input logic [31:0] xv, input logic [31:0] yv, input logic ov);
    vecs[i].c[4] = c4;
    vecs[i].c[3] = c3;
    vecs[i].c[2] = c2;
    vecs[i].c[1] = c1;
    vecs[i].c[0] = c0;
    vecs[i].xv   = xv;
    vecs[i].yv   = yv;
    vecs[i].ov   = ov;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] yv;
    logic        ov;
    logic [31:0] ey;
    logic        eo;
    int          lat;
    int          seen;

    reset     = 1'b1;
    coef_we   = 1'b0;
    coef_addr = 4'd0;
    coef_data = 32'd0;
    start     = 1'b0;
    x         = 32'd0;
    last_y    = 32'd0;

    set_vec(0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h3F800000, 32'h40000000, 32'h3F800000, 1'b0);
    set_vec(1, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
            32'h40000000, 32'h41F80000, 1'b0);
    set_vec(2, 32'h0, 32'h0, 32'h0, 32'h3F800000, 32'hC0000000, 32'h40000000, 32'h0, 1'b0);
    set_vec(3, 32'h7F000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h7F000000, 32'h7F800000, 1'b1);
    set_vec(4, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
            32'h3FC00000, 32'h41530000, 1'b0);
    set_vec(5, 32'h0, 32'h0, 32'h0, 32'h3F800000, 32'hB3000000, 32'h3F800000, 32'h3F7FFFFF, 1'b0);
    set_vec(6, 32'h0, 32'h0, 32'h0, 32'h3F800000, 32'h33800000, 32'h3F800000, 32'h3F800000, 1'b0);
    set_vec(7, 32'h0, 32'h0, 32'h0, 32'h00800000, 32'h0, 32'h3F000000, 32'h0, 1'b0);
    set_vec(8, 32'hFF000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h7F000000, 32'hFF800000, 1'b1);
    set_vec(9, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
            32'h7FC00000, 32'h7FC00000, 1'b1);

    do_reset();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_y", y, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);

    // directed vector table
    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i <= DEG; i++) write_coef(4'(i), vecs[v].c[i]);
      run_eval(vecs[v].xv, 1'b0, yv, ov);
      check($sformatf("vec%0d_y", v), yv, vecs[v].yv);
      check($sformatf("vec%0d_ovf", v), {31'd0, ov}, {31'd0, vecs[v].ov});
    end

    // start at T+3 and a coefficient write at T+4 are both ignored
    for (int i = 0; i <= DEG; i++) write_coef(4'(i), 32'h3F800000);
    @(negedge clk);
    start = 1'b1;
    x     = 32'h40000000;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      start = (lat == 3);
      x     = (lat == 3) ? 32'h40400000 : 32'h0;
      coef_we   = (lat == 4);
      coef_addr = 4'd0;
      coef_data = 32'h40000000;
    end
    start   = 1'b0;
    coef_we = 1'b0;
    check("ign_latency", 32'(lat), 32'(LAT));
    check("ign_y", y, 32'h41F80000);
    last_y = y;
    run_eval(32'h40000000, 1'b0, yv, ov);
    check("ign_coef_kept", yv, 32'h41F80000);

    // back-to-back start in the IDLE cycle right after done
    run_eval(32'h3FC00000, 1'b1, yv, ov);
    check("b2b_y", yv, 32'h41530000);

    // reset at T+5 aborts; reset wins over start and coef_we
    @(negedge clk);
    start = 1'b1;
    x     = 32'h40000000;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_y", y, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    start     = 1'b1;
    coef_we   = 1'b1;
    coef_addr = 4'd0;
    coef_data = 32'h3F800000;
    @(negedge clk);
    reset   = 1'b0;
    start   = 1'b0;
    coef_we = 1'b0;
    check("rst_prio_busy", {31'd0, busy}, 32'd0);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    for (int i = 0; i <= DEG; i++) model_c[i] = 32'd0;
    last_y = 32'd0;
    run_eval({1'b0, 8'($urandom_range(100, 150)), 23'($urandom)}, 1'b0, yv, ov);
    check("abort_coefs_zero", yv, 32'd0);
    check("abort_ovf", {31'd0, ov}, 32'd0);

    // randomized polynomials against the reference model
    for (int n = 0; n < 40; n++) begin
      bit b2b;
      logic [31:0] xv;
      b2b = ($urandom_range(0, 3) == 0);
      if (!b2b) begin
        repeat ($urandom_range(1, 4)) write_coef(4'($urandom_range(0, 7)), rand_fp(118, 136));
      end
      xv = rand_fp(122, 132);
      ey = ref_eval(xv, eo);
      exp_q.push_back(ey);
      exp_ovf_q.push_back(eo);
      run_eval(xv, b2b, yv, ov);
      check($sformatf("rand%0d_y", n), yv, exp_q.pop_front());
      check($sformatf("rand%0d_ovf", n), {31'd0, ov}, {31'd0, exp_ovf_q.pop_front()});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
